// File: rtl/tpu_host_writeback_if.sv
// Host write-back bus: command handshake plus the outbound word beat stream.
// master = write-back engine (drives cmd_ready, host_rdata*), slave = host.
interface tpu_host_writeback_if #(
  parameter int N   = 4,
  parameter int AW  = 32,
  parameter int HAW = 12,
  parameter int CW  = $clog2(N) + 1
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [HAW-1:0] cmd_base_addr;
  logic [CW-1:0]  cmd_count;
  logic [AW-1:0]  host_rdata;
  logic [HAW-1:0] host_rdata_address;
  logic           host_rdata_valid;
  logic           host_rdata_ready;

  modport master (
    input  cmd_valid, cmd_base_addr, cmd_count,
    input  host_rdata_ready,
    output cmd_ready,
    output host_rdata, host_rdata_address, host_rdata_valid
  );

  modport slave (
    output cmd_valid, cmd_base_addr, cmd_count,
    output host_rdata_ready,
    input  cmd_ready,
    input  host_rdata, host_rdata_address, host_rdata_valid
  );
endinterface

// File: rtl/tpu_host_writeback.sv
// Buffers one accumulator row and streams it to the host, one word per beat.
// Ports: clk, reset_n, acc_row_valid/acc_row in, bus (master), wb_done, row_overflow out.
module tpu_host_writeback #(
  parameter int N   = 4,
  parameter int AW  = 32,
  parameter int HAW = 12,
  parameter int CW  = $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                acc_row_valid,
  input  logic [N*AW-1:0]     acc_row,
  tpu_host_writeback_if.master bus,
  output logic                wb_done,
  output logic                row_overflow
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ROW,
    SEND,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  row_q [N];
  logic           row_full_q;
  logic           armed_q;
  logic [HAW-1:0] base_q;
  logic [CW-1:0]  cnt_q, idx_q, cnt_in;
  logic           accept, beat, last;

  assign cnt_in = (bus.cmd_count > CW'(N)) ? CW'(N) : bus.cmd_count;

  // armed_q keeps cmd_ready low while reset is asserted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      row_full_q   <= 1'b0;
      row_overflow <= 1'b0;
      base_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      for (int i = 0; i < N; i++) row_q[i] <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (accept) begin
        base_q <= bus.cmd_base_addr;
        cnt_q  <= cnt_in;
        idx_q  <= '0;
      end else if (beat) begin
        idx_q  <= idx_q + CW'(1);
      end
      if (acc_row_valid && state_q != SEND) begin
        for (int i = 0; i < N; i++) row_q[i] <= acc_row[i*AW +: AW];
        row_full_q <= 1'b1;
      end else if (last) begin
        row_full_q <= 1'b0;
      end
      // set beats clear if both happen together
      if (acc_row_valid && state_q == SEND) row_overflow <= 1'b1;
      else if (accept)                     row_overflow <= 1'b0;
    end
  end

  always_comb begin
    state_d              = state_q;
    bus.cmd_ready        = 1'b0;
    bus.host_rdata_valid = 1'b0;
    bus.host_rdata       = '0;
    bus.host_rdata_address = '0;
    wb_done              = 1'b0;
    accept               = 1'b0;
    beat                 = 1'b0;
    last                 = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = armed_q;
        accept        = armed_q & bus.cmd_valid;
        if (accept) begin
          if (cnt_in == '0)                    state_d = DONE;
          else if (row_full_q || acc_row_valid) state_d = SEND;
          else                                 state_d = WAIT_ROW;
        end
      end
      WAIT_ROW: begin
        if (acc_row_valid) state_d = SEND;
      end
      SEND: begin
        bus.host_rdata_valid   = 1'b1;
        bus.host_rdata         = row_q[idx_q[IW-1:0]];
        bus.host_rdata_address = base_q + HAW'(idx_q);
        beat = bus.host_rdata_ready;
        last = beat && (idx_q == cnt_q - CW'(1));
        if (last) state_d = DONE;
      end
      DONE: begin
        wb_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tpu_host_writeback.sv
// Directed bench for tpu_host_writeback: vector table plus corner sequences.
// Drives the slave side of the bus; all expectations are hand-written.
module tb_tpu_host_writeback;
  logic          clk = 1'b0;
  logic          reset_n;
  logic          acc_row_valid;
  logic [127:0]  acc_row;
  logic          wb_done;
  logic          row_overflow;

  tpu_host_writeback_if bus ();

  tpu_host_writeback dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .acc_row_valid(acc_row_valid),
    .acc_row      (acc_row),
    .bus          (bus.master),
    .wb_done      (wb_done),
    .row_overflow (row_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] w;
    logic [11:0]      base;
    logic [2:0]       count;
    int               nbeats;
    bit               pre;
    bit               tog;
  } vec_t;

  vec_t             vt [5];
  logic [3:0][31:0] exp_row;
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [3:0][31:0] r);
    acc_row       = r;
    acc_row_valid = 1'b1;
    tick();
    acc_row_valid = 1'b0;
  endtask

  task automatic issue(input logic [11:0] base, input logic [2:0] cnt);
    int k = 0;
    while (!bus.cmd_ready && k < 20) begin
      tick();
      k++;
    end
    check("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid     = 1'b1;
    bus.cmd_base_addr = base;
    bus.cmd_count     = cnt;
    tick();
    bus.cmd_valid     = 1'b0;
  endtask

  task automatic collect(input logic [11:0] base, input int nexp,
                         input bit tog);
    int          beats = 0;
    int          cyc = 0;
    int          dones = 0;
    int          first_at = -1;
    int          last_at = -1;
    int          done_at = -1;
    bit          stall = 1'b0;
    logic [31:0] sd;
    logic [11:0] sa, ea;
    while (cyc < 60 && dones == 0) begin
      bus.host_rdata_ready = tog ? (cyc % 3 == 0) : 1'b1;
      if (stall) begin
        check("stall_valid", 64'(bus.host_rdata_valid), 64'd1);
        check("stall_data", 64'(bus.host_rdata), 64'(sd));
        check("stall_addr", 64'(bus.host_rdata_address), 64'(sa));
      end
      if (wb_done) begin
        dones++;
        done_at = cyc;
      end
      stall = 1'b0;
      if (bus.host_rdata_valid) begin
        if (first_at < 0) first_at = cyc;
        if (beats < nexp) begin
          ea = base + 12'(beats);
          check("beat_data", 64'(bus.host_rdata), 64'(exp_row[beats]));
          check("beat_addr", 64'(bus.host_rdata_address), 64'(ea));
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got beat %0d want %0d beats",
                   beats + 1, nexp);
        end
        if (bus.host_rdata_ready) begin
          beats++;
          last_at = cyc;
        end else begin
          stall = 1'b1;
          sd    = bus.host_rdata;
          sa    = bus.host_rdata_address;
        end
      end
      tick();
      cyc++;
    end
    check("beat_count", 64'(beats), 64'(nexp));
    check("done_count", 64'(dones), 64'd1);
    check("done_timing", 64'(done_at), 64'(last_at + 1));
    if (nexp > 0) check("first_latency", 64'(first_at), 64'd0);
    check("done_one_cycle", 64'(wb_done), 64'd0);
    bus.host_rdata_ready = 1'b1;
  endtask

  initial begin
    vt[0] = '{w: '{32'h7FFFFFFF, 32'd3, 32'hFFFFFFFE, 32'd1},
              base: 12'h010, count: 3'd4, nbeats: 4, pre: 1, tog: 0};
    vt[1] = '{w: '{32'd8, 32'd7, 32'd6, 32'd5},
              base: 12'h020, count: 3'd2, nbeats: 2, pre: 0, tog: 0};
    vt[2] = '{w: '{32'hD, 32'hC, 32'hB, 32'hA},
              base: 12'hFFE, count: 3'd4, nbeats: 4, pre: 1, tog: 1};
    vt[3] = '{w: '{32'd4, 32'd3, 32'd2, 32'd1},
              base: 12'h100, count: 3'd0, nbeats: 0, pre: 1, tog: 0};
    vt[4] = '{w: '{32'd42, 32'd0, 32'h80000000, 32'hFFFFFFFF},
              base: 12'h200, count: 3'd7, nbeats: 4, pre: 1, tog: 0};

    reset_n              = 1'b0;
    acc_row_valid        = 1'b0;
    acc_row              = '0;
    bus.cmd_valid        = 1'b0;
    bus.cmd_base_addr    = '0;
    bus.cmd_count        = '0;
    bus.host_rdata_ready = 1'b1;
    #2;
    check("rst_valid", 64'(bus.host_rdata_valid), 64'd0);
    check("rst_data", 64'(bus.host_rdata), 64'd0);
    check("rst_addr", 64'(bus.host_rdata_address), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_done", 64'(wb_done), 64'd0);
    check("rst_ovf", 64'(row_overflow), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      exp_row = vt[i].w;
      if (vt[i].pre) begin
        send_row(vt[i].w);
        issue(vt[i].base, vt[i].count);
      end else begin
        issue(vt[i].base, vt[i].count);
        for (int k = 0; k < 3; k++) begin
          check("wait_no_valid", 64'(bus.host_rdata_valid), 64'd0);
          check("wait_no_ready", 64'(bus.cmd_ready), 64'd0);
          tick();
        end
        send_row(vt[i].w);
      end
      collect(vt[i].base, vt[i].nbeats, vt[i].tog);
      tick();
    end

    exp_row = '{32'h44, 32'h33, 32'h22, 32'h11};
    send_row(exp_row);
    bus.host_rdata_ready = 1'b0;
    issue(12'h300, 3'd4);
    send_row('{32'hDD, 32'hCC, 32'hBB, 32'hAA});
    check("ovf_set", 64'(row_overflow), 64'd1);
    check("ovf_data_kept", 64'(bus.host_rdata), 64'h11);
    collect(12'h300, 4, 1'b0);
    check("ovf_sticky", 64'(row_overflow), 64'd1);
    issue(12'h000, 3'd0);
    check("ovf_cleared", 64'(row_overflow), 64'd0);
    tick();
    tick();

    exp_row = '{32'h4, 32'h3, 32'h2, 32'h1};
    send_row(exp_row);
    bus.host_rdata_ready = 1'b0;
    issue(12'h040, 3'd4);
    check("pre_rst_valid", 64'(bus.host_rdata_valid), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.host_rdata_valid), 64'd0);
    check("arst_data", 64'(bus.host_rdata), 64'd0);
    check("arst_addr", 64'(bus.host_rdata_address), 64'd0);
    check("arst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    tick();
    check("arst_done", 64'(wb_done), 64'd0);
    reset_n = 1'b1;
    bus.host_rdata_ready = 1'b1;
    tick();
    issue(12'h050, 3'd3);
    check("post_rst_row_gone", 64'(bus.host_rdata_valid), 64'd0);
    exp_row = '{32'h0, 32'hC3, 32'hB2, 32'hA1};
    send_row(exp_row);
    collect(12'h050, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
